// File: rtl/mouse_vga_pkg.sv
// Shared types and helpers for the mouse cursor overlay: the RGB565 pixel
// type, the 3-bit colour palette and the mouse-delta sign extension.
package mouse_vga_pkg;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t RGB_BLACK = 16'h0000;

  // Width of the sign-extended delta; callers slice down to their own width.
  localparam int DELTA_EXT_W = 16;

  // Index bit0 lights red, bit1 green, bit2 blue (0 = black, 7 = white).
  function automatic rgb565_t palette(input logic [2:0] idx);
    return {(idx[0] ? 5'h1F : 5'h00),
            (idx[1] ? 6'h3F : 6'h00),
            (idx[2] ? 5'h1F : 5'h00)};
  endfunction

  // 9-bit two's-complement mouse delta (bit 8 = sign) to DELTA_EXT_W bits.
  function automatic logic signed [DELTA_EXT_W-1:0] sext_delta(input logic [8:0] d);
    return {{(DELTA_EXT_W-9){d[8]}}, d};
  endfunction

endpackage

// File: rtl/cursor_axis.sv
// One cursor axis: pending position updated on each mouse packet with clamp
// or wrap at the borders, and a committed copy refreshed once per frame.
module cursor_axis
  import mouse_vga_pkg::*;
#(
  parameter int RES     = 640,
  parameter int SIZE    = 16,
  parameter int WRAP    = 0,
  parameter int INVERT  = 0,
  parameter int COORD_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [8:0]         delta,
  input  logic               done_tick,
  input  logic               frame_start,
  output logic [COORD_W-1:0] pos
);

  localparam int W = COORD_W + 2;
  localparam logic [COORD_W-1:0]  HOME    = COORD_W'((RES - SIZE) / 2);
  localparam logic signed [W-1:0] MAX_POS = W'(RES - SIZE);
  localparam logic signed [W-1:0] RES_S   = W'(RES);

  logic [COORD_W-1:0]          pending;
  logic signed [DELTA_EXT_W-1:0] d_full;
  logic signed [W-1:0]         d_ext;
  logic signed [W-1:0]         p_ext;
  logic signed [W-1:0]         n_raw;
  logic signed [W-1:0]         n_fix;
  logic [COORD_W-1:0]          next_pos;

  assign d_full = sext_delta(delta);
  assign d_ext  = $signed(d_full[W-1:0]);
  assign p_ext  = $signed({2'b00, pending});
  // Screen Y grows downward while mouse-up is positive, so Y subtracts.
  assign n_raw  = (INVERT != 0) ? (p_ext - d_ext) : (p_ext + d_ext);

  // Border handling; one wrap correction suffices since |delta| < RES.
  always_comb begin
    n_fix = n_raw;
    if (WRAP == 0) begin
      if (n_raw < 0)            n_fix = '0;
      else if (n_raw > MAX_POS) n_fix = MAX_POS;
    end else begin
      if (n_raw < 0)            n_fix = n_raw + RES_S;
      else if (n_raw >= RES_S)  n_fix = n_raw - RES_S;
    end
    next_pos = n_fix[COORD_W-1:0];
  end

  // Pending follows packets; committed samples the pre-tick pending value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= HOME;
      pos     <= HOME;
    end else begin
      if (done_tick)   pending <= next_pos;
      if (frame_start) pos     <= pending;
    end
  end

endmodule

// File: rtl/mouse_cursor_overlay.sv
// Mouse pointer engine for the VGA path: tracks the cursor from decoded
// PS/2 packets, steps the cursor colour on button presses, commits both at
// frame start and overlays the cursor onto the background pixel stream.
//
// m_done_tick and frame_start are single-cycle strobes with no backpressure:
// the packet fields are only meaningful in the cycle m_done_tick is high.
module mouse_cursor_overlay
  import mouse_vga_pkg::*;
#(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int SIZE    = 16,
  parameter int WRAP    = 0,
  parameter int OUTLINE = 1,
  parameter int COORD_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [8:0]         m_dx,
  input  logic [8:0]         m_dy,
  input  logic [2:0]         m_btn,
  input  logic               m_done_tick,
  input  logic               frame_start,
  input  logic               video_on,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic [15:0]        bg_rgb,
  output logic [15:0]        rgb_out,
  output logic [COORD_W-1:0] cursor_x,
  output logic [COORD_W-1:0] cursor_y,
  output logic [2:0]         btn_press
);

  localparam logic [COORD_W:0] SIZE_E = (COORD_W+1)'(SIZE);

  logic [2:0] prev_btn;
  logic [2:0] press;
  logic [2:0] pend_col;
  logic [2:0] com_col;

  cursor_axis #(
    .RES(H_RES), .SIZE(SIZE), .WRAP(WRAP), .INVERT(0), .COORD_W(COORD_W)
  ) u_axis_x (
    .clk(clk), .rst_n(rst_n), .delta(m_dx), .done_tick(m_done_tick),
    .frame_start(frame_start), .pos(cursor_x)
  );

  cursor_axis #(
    .RES(V_RES), .SIZE(SIZE), .WRAP(WRAP), .INVERT(1), .COORD_W(COORD_W)
  ) u_axis_y (
    .clk(clk), .rst_n(rst_n), .delta(m_dy), .done_tick(m_done_tick),
    .frame_start(frame_start), .pos(cursor_y)
  );

  assign press = m_btn & ~prev_btn;

  // Button edge detect and pending colour: middle resets, right +1, left -1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_btn  <= '0;
      btn_press <= '0;
      pend_col  <= '0;
    end else if (m_done_tick) begin
      prev_btn  <= m_btn;
      btn_press <= press;
      if (press[2])                  pend_col <= 3'd0;
      else if (press[1] && !press[0]) pend_col <= pend_col + 3'd1;
      else if (press[0] && !press[1]) pend_col <= pend_col - 3'd1;
    end else begin
      btn_press <= '0;
    end
  end

  // Colour becomes visible only at frame start, together with the position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           com_col <= '0;
    else if (frame_start) com_col <= pend_col;
  end

  // Hit test in one extra bit so a cursor hanging off the edge is clipped.
  logic [COORD_W:0] px_e, py_e, x_end, y_end;
  logic             on_x, on_y, hit, on_edge;

  always_comb begin
    px_e    = {1'b0, pixel_x};
    py_e    = {1'b0, pixel_y};
    x_end   = {1'b0, cursor_x} + SIZE_E;
    y_end   = {1'b0, cursor_y} + SIZE_E;
    on_x    = (pixel_x >= cursor_x) && (px_e < x_end);
    on_y    = (pixel_y >= cursor_y) && (py_e < y_end);
    hit     = on_x && on_y;
    on_edge = hit && ((pixel_x == cursor_x) || (px_e == x_end - 1'b1) ||
                      (pixel_y == cursor_y) || (py_e == y_end - 1'b1));
  end

  // Registered pixel mux: blanking, outline, cursor body, background.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       rgb_out <= RGB_BLACK;
    else if (!video_on)               rgb_out <= RGB_BLACK;
    else if (on_edge && OUTLINE != 0) rgb_out <= RGB_BLACK;
    else if (hit)                     rgb_out <= palette(com_col);
    else                              rgb_out <= bg_rgb;
  end

endmodule

// File: doc/mouse_cursor_overlay.md
Name: mouse_cursor_overlay

Overview:
- Parametrised PS/2 mouse pointer engine for the VGA path: consumes decoded mouse packets, tracks the cursor position with clamp or wrap boundary modes, and changes cursor colour on button press edges.
- Commits position and colour at frame boundaries to prevent tearing.
- Overlays an N×N cursor, with an optional outline, onto a supplied background pixel, using a registered RGB565 output.
- Sits between the PS/2 mouse receiver and the VGA pins, in the pixel-clock domain.

Parameters:
H_RES, 640, visible width in pixels
V_RES, 480, visible height in pixels
SIZE, 16, cursor width and height in pixels (2..64)
WRAP, 0, 0 = clamp at borders, 1 = wrap around the screen
OUTLINE, 1, 1 = draw the cursor's outer 1-pixel ring in black (565'h0000)
COORD_W, 12, width of the pixel coordinate ports

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
m_dx  in  9  signed 2's-complement X delta (bit 8 = sign), valid with m_done_tick
m_dy  in  9  signed Y delta; mouse up = positive
m_btn  in  3  {middle,right,left} button levels, valid with m_done_tick
m_done_tick  in  1  one-cycle packet-valid strobe
frame_start  in  1  one-cycle pulse at the start of vertical blanking
video_on  in  1  visible-area flag
pixel_x  in  COORD_W  current pixel column
pixel_y  in  COORD_W  current pixel row
bg_rgb  in  16  background RGB565 for the current pixel
rgb_out  out  16  overlaid RGB565, registered
cursor_x  out  COORD_W  committed cursor left edge
cursor_y  out  COORD_W  committed cursor top edge
btn_press  out  3  one-cycle pulse per button press edge

Behaviour:
- Reset (async, rst_n=0):
  - pending and committed X = (H_RES-SIZE)/2; Y = (V_RES-SIZE)/2.
  - Pending and committed colour index = 0; previous-button register = 0.
  - btn_press = 0; rgb_out = 0.
  - Reset asserted mid-packet: the packet is discarded with no partial update.
- Position update, on m_done_tick only:
  - Sign-extend each delta to COORD_W+2 bits.
  - nx = px + dx.
  - ny = py - dy (screen Y grows downward).
- Clamp mode (WRAP=0):
  - nx < 0 -> 0; nx > H_RES-SIZE -> H_RES-SIZE.
  - ny < 0 -> 0; ny > V_RES-SIZE -> V_RES-SIZE.
- Wrap mode (WRAP=1):
  - nx < 0 -> nx+H_RES; nx >= H_RES -> nx-H_RES. Y uses V_RES the same way.
  - A single correction is sufficient because |delta| <= 256 < resolution; this is required, not optional.
  - A cursor crossing the right or bottom edge is clipped, never split.
- Buttons:
  - press[i] = m_btn[i] & ~prev[i], evaluated on m_done_tick; prev <= m_btn on the same tick.
  - btn_press <= press, registered one cycle after the tick; otherwise 0.
  - Holding a button across packets produces no further presses.
- Pending colour (3-bit, wraps mod 8):
  - Right press only: +1.
  - Left press only: -1.
  - Right and left together: unchanged.
  - Middle press: set to 0, overriding left and right.
- Commit:
  - On frame_start, committed position and colour <= pending values.
  - If m_done_tick and frame_start coincide, commit takes the pre-tick pending values; the new packet becomes visible on the next frame.
- Hit test:
  - on = cursor_x <= pixel_x < cursor_x+SIZE and cursor_y <= pixel_y < cursor_y+SIZE. The interval is exactly SIZE pixels.
  - edge = on and the pixel lies in the first or last column or row of the cursor.
- Pixel output: registered, latency 1 cycle (rgb_out at n+1 reflects inputs at n).
  - Not video_on -> 0.
  - on & edge & OUTLINE -> 0x0000.
  - on -> palette(colour).
  - Otherwise -> bg_rgb.
- Palette: bit0 -> R = 5'h1F, bit1 -> G = 6'h3F, bit2 -> B = 5'h1F. Index 0 = black, 7 = white.

Decomposition:
- Package mouse_vga_pkg holds:
  - rgb565_t typedef and the palette function (3-bit index -> rgb565_t).
  - RGB_BLACK constant.
  - A delta sign-extend function.
- Sub-module cursor_axis, instantiated twice (X with INVERT=0, Y with INVERT=1).
  - Parameters: RES, SIZE, WRAP, INVERT.
  - Holds the pending and committed registers and the clamp/wrap arithmetic.
- Top level holds the button edge logic, the colour register and the pixel stage.

Test Plan:
- Reset, then one frame_start -> cursor_x=312, cursor_y=232, rgb_out=0 during reset; rgb_out=bg_rgb off-cursor once video_on.
- WRAP=0: from (312,232), dx=-256 twice, frame_start -> cursor_x=0. dx=+255 ×3 -> cursor_x=624. dy=+100 from y=50 -> y=0.
- WRAP=1: from x=10, dx=-20, frame_start -> x=630. Then dx=+15 -> x=5. A pixel at column 639 with cursor at 630 is cursor-coloured; column 0 is background.
- Buttons:
  - Right press, release, press (3 packets) -> colour 2 and btn_press[1] pulses twice.
  - Held right over 4 packets -> one increment.
  - Left+right pressed together -> unchanged.
  - Middle press -> 0.
  - Left from 0 -> 7.
- Coincident m_done_tick and frame_start with dx=+8 -> cursor_x unchanged this frame; +8 applied after the next frame_start.
- Pixel stage, cursor at (100,100), colour 7, OUTLINE=1:
  - pixel (100,105) -> 0x0000.
  - pixel (107,107) -> 0xFFFF.
  - pixel (116,107) -> bg_rgb.
  - Every rgb_out change appears exactly one cycle after its input.
